// File: rtl/l2_reqs_tracker.sv
// l2_reqs_tracker: N_REQS-entry MSHR tracker with set/tag lookup and signed inv-ack accounting.
// Define L2_REQS_STATS_EN to implement the stat_peak / stat_full_stalls counters.
`ifndef L2_TAG_BITS
`define L2_TAG_BITS 8
`endif
`ifndef L2_SET_BITS
`define L2_SET_BITS 4
`endif
`ifndef L2_WAY_BITS
`define L2_WAY_BITS 2
`endif
`ifndef UNSTABLE_STATE_BITS
`define UNSTABLE_STATE_BITS 3
`endif
`ifndef INVACK_CNT_WIDTH
`define INVACK_CNT_WIDTH 3
`endif
`ifndef INVACK_CNT_CALC_WIDTH
`define INVACK_CNT_CALC_WIDTH 4
`endif

module l2_reqs_tracker #(
  parameter int N_REQS  = 4,
  parameter int TAG_W   = `L2_TAG_BITS,
  parameter int SET_W   = `L2_SET_BITS,
  parameter int WAY_W   = `L2_WAY_BITS,
  parameter int STATE_W = `UNSTABLE_STATE_BITS,
  parameter int ICNT_W  = `INVACK_CNT_CALC_WIDTH,
  parameter int RCNT_W  = `INVACK_CNT_WIDTH,
  localparam int IDX_W  = $clog2(N_REQS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic [TAG_W-1:0]   alloc_tag,
  input  logic [SET_W-1:0]   alloc_set,
  input  logic [WAY_W-1:0]   alloc_way,
  input  logic [STATE_W-1:0] alloc_state,
  output logic [IDX_W-1:0]   alloc_idx,
  input  logic [TAG_W-1:0]   lookup_tag,
  input  logic [SET_W-1:0]   lookup_set,
  output logic               lookup_hit,
  output logic [IDX_W-1:0]   lookup_idx,
  output logic [WAY_W-1:0]   lookup_way,
  output logic [STATE_W-1:0] lookup_state,
  output logic               lookup_set_conflict,
  input  logic               upd_valid,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic [STATE_W-1:0] upd_state,
  input  logic               inv_dec_valid,
  input  logic [IDX_W-1:0]   inv_dec_idx,
  input  logic               rsp_cnt_valid,
  input  logic [IDX_W-1:0]   rsp_cnt_idx,
  input  logic [RCNT_W-1:0]  rsp_cnt,
  input  logic               free_valid,
  input  logic [IDX_W-1:0]   free_idx,
  output logic [N_REQS-1:0]  invack_done,
  output logic [IDX_W:0]     count,
  output logic               empty,
  output logic [IDX_W:0]     stat_peak,
  output logic [15:0]        stat_full_stalls
);

  localparam int CNT_MAX = (1 << (ICNT_W - 1)) - 1;
  localparam int CNT_MIN = -(1 << (ICNT_W - 1));

  logic [N_REQS-1:0]  valid_vec;
  logic [N_REQS-1:0]  hit_vec;
  logic [N_REQS-1:0]  set_vec;
  logic [WAY_W-1:0]   way_arr   [N_REQS];
  logic [STATE_W-1:0] state_arr [N_REQS];
  logic               alloc_fire;
  logic               free_ok;
  logic [IDX_W:0]     count_q, count_d;

  assign alloc_ready = ~&valid_vec;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign free_ok     = free_valid && valid_vec[free_idx];

  always_comb begin
    alloc_idx = '0;
    for (int i = N_REQS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  for (genvar gi = 0; gi < N_REQS; gi++) begin : g_ent
    logic                     valid_q, valid_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [SET_W-1:0]         set_q, set_d;
    logic [WAY_W-1:0]         way_q, way_d;
    logic [STATE_W-1:0]       state_q, state_d;
    logic signed [ICNT_W-1:0] cnt_q, cnt_d;
    logic                     got_q, got_d;
    logic                     done_q, done_d;
    logic                     alloc_here, free_here, upd_here, inv_here, rsp_here, ovf;
    int                       sum;

    assign alloc_here = alloc_fire && (alloc_idx == IDX_W'(gi));
    assign free_here  = free_ok && (free_idx == IDX_W'(gi));
    assign upd_here   = upd_valid && (upd_idx == IDX_W'(gi));
    assign inv_here   = inv_dec_valid && (inv_dec_idx == IDX_W'(gi));
    assign rsp_here   = rsp_cnt_valid && (rsp_cnt_idx == IDX_W'(gi));

    // Free wins over any update to the same entry; alloc only ever targets a free slot.
    always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      set_d   = set_q;
      way_d   = way_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      got_d   = got_q;
      ovf     = 1'b0;
      sum     = int'(cnt_q) + (rsp_here ? int'(rsp_cnt) : 0) - (inv_here ? 1 : 0);
      if (alloc_here) begin
        valid_d = 1'b1;
        tag_d   = alloc_tag;
        set_d   = alloc_set;
        way_d   = alloc_way;
        state_d = alloc_state;
        cnt_d   = '0;
        got_d   = 1'b0;
      end else if (free_here) begin
        valid_d = 1'b0;
        cnt_d   = '0;
        got_d   = 1'b0;
      end else if (valid_q) begin
        if (upd_here) state_d = upd_state;
        cnt_d = sum[ICNT_W-1:0];
        got_d = got_q | rsp_here;
        ovf   = (sum > CNT_MAX) || (sum < CNT_MIN);
      end
      done_d = valid_d && got_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        set_q   <= '0;
        way_q   <= '0;
        state_q <= '0;
        cnt_q   <= '0;
        got_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        set_q   <= set_d;
        way_q   <= way_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        got_q   <= got_d;
        done_q  <= done_d;
        assert (!((upd_here || inv_here || rsp_here) && !valid_q))
          else $error("l2_reqs_tracker: update to invalid entry %0d", gi);
        assert (!ovf) else $error("l2_reqs_tracker: inv-ack count overflow on entry %0d", gi);
      end
    end

    assign valid_vec[gi]   = valid_q;
    assign hit_vec[gi]     = valid_q && (set_q == lookup_set) && (tag_q == lookup_tag);
    assign set_vec[gi]     = valid_q && (set_q == lookup_set);
    assign way_arr[gi]     = way_q;
    assign state_arr[gi]   = state_q;
    assign invack_done[gi] = done_q;
  end

  always_comb begin
    lookup_hit   = 1'b0;
    lookup_idx   = '0;
    lookup_way   = '0;
    lookup_state = '0;
    for (int i = N_REQS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        lookup_hit   = 1'b1;
        lookup_idx   = IDX_W'(i);
        lookup_way   = way_arr[i];
        lookup_state = state_arr[i];
      end
    end
  end
  assign lookup_set_conflict = |set_vec;

  always_comb begin
    count_d = count_q;
    if (alloc_fire && !free_ok)      count_d = count_q + (IDX_W+1)'(1);
    else if (!alloc_fire && free_ok) count_d = count_q - (IDX_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
      assert ($onehot0(hit_vec)) else $error("l2_reqs_tracker: multiple lookup hits");
      assert (!(free_valid && !free_ok)) else $error("l2_reqs_tracker: free of invalid entry");
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

`ifdef L2_REQS_STATS_EN
  logic [IDX_W:0] peak_q, peak_d;
  logic [15:0]    stalls_q, stalls_d;

  // Peak tracks next-count so it is never a cycle behind count.
  always_comb begin
    peak_d   = (count_d > peak_q) ? count_d : peak_q;
    stalls_d = stalls_q;
    if (alloc_valid && !alloc_ready && (stalls_q != 16'hFFFF)) stalls_d = stalls_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q   <= '0;
      stalls_q <= '0;
    end else begin
      peak_q   <= peak_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_peak        = peak_q;
  assign stat_full_stalls = stalls_q;
`else
  assign stat_peak        = '0;
  assign stat_full_stalls = '0;
`endif

endmodule
